// File: rtl/status_panel_pkg.sv
// Shared types and constants for the status panel scheduler.
package status_panel_pkg;

  typedef enum logic {ARB = 1'b0, ACK = 1'b1} arb_state_e;

  localparam logic [7:0] BLANK_GLYPH = 8'h20;
  localparam int         VIS_H       = 480;
  localparam int         CELL_W      = 16;
  localparam int         CELL_H      = 32;

endpackage

// File: rtl/status_panel_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid requester searching from last+1.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [LW-1:0]      last_i,
  output logic [LW-1:0]      winner_o,
  output logic               any_valid_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    idx         = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_i) + i) % NUM_REQ;
      if (req_valid_i[idx]) begin
        winner_o    = LW'(idx);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/status_panel_scheduler.sv
// Shares the four-panel status text between requesters and feeds the glyph renderer.
// Optional alarm blinking is built when STATUS_PANEL_BLINK_EN is defined.
module status_panel_scheduler
  import status_panel_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int N_CHARS = 8,
  parameter int TEXT_X0 = 32,
  parameter int TEXT_Y0 = 44,
  parameter int PANEL_H = 120
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET_N,
  input  logic [9:0]                    x,
  input  logic [9:0]                    y,
  input  logic                          display_area,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [2*NUM_REQ-1:0]          req_panel,
  input  logic [$clog2(N_CHARS)*NUM_REQ-1:0] req_idx,
  input  logic [8*NUM_REQ-1:0]          req_code,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3:0]                    alarm,
  output logic                          char_valid,
  output logic [7:0]                    char_code,
  output logic [9:0]                    char_start_x,
  output logic [9:0]                    char_start_y
);

  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = $clog2(N_CHARS);
  localparam logic [9:0] X_LO = 10'(TEXT_X0);
  localparam logic [9:0] X_HI = 10'(TEXT_X0 + CELL_W * N_CHARS);

  arb_state_e         state_q;
  logic [LW-1:0]      win_q, last_q, winner;
  logic [NUM_REQ-1:0] ready_q;
  logic               any_valid;

  logic [1:0]    panel_a [NUM_REQ];
  logic [CW-1:0] idx_a   [NUM_REQ];
  logic [7:0]    code_a  [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign panel_a[r] = req_panel[2*r +: 2];
    assign idx_a[r]   = req_idx[CW*r +: CW];
    assign code_a[r]  = req_code[8*r +: 8];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .LW(LW)) u_arb (
    .req_valid_i (req_valid),
    .last_i      (last_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= ARB;
      ready_q <= '0;
      last_q  <= LW'(NUM_REQ - 1);
      win_q   <= '0;
    end else begin
      case (state_q)
        ARB: if (any_valid) begin
          win_q   <= winner;
          ready_q <= NUM_REQ'(1) << winner;
          state_q <= ACK;
        end
        ACK: begin
          last_q  <= win_q;
          ready_q <= '0;
          state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign req_ready = ready_q;

  logic [7:0] shadow_q [4][N_CHARS];
  logic [7:0] front_q  [4][N_CHARS];
  logic       vb_q, vb_d, commit;

  assign vb_d   = (y >= 10'(VIS_H));
  assign commit = vb_d & ~vb_q;

  // Front copy reads the pre-write shadow, so a colliding write shows next frame.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      vb_q <= 1'b0;
      for (int p = 0; p < 4; p++)
        for (int c = 0; c < N_CHARS; c++) begin
          shadow_q[p][c] <= BLANK_GLYPH;
          front_q[p][c]  <= BLANK_GLYPH;
        end
    end else begin
      vb_q <= vb_d;
      if (commit)
        for (int p = 0; p < 4; p++)
          for (int c = 0; c < N_CHARS; c++)
            front_q[p][c] <= shadow_q[p][c];
      if (state_q == ACK)
        shadow_q[panel_a[win_q]][idx_a[win_q]] <= code_a[win_q];
    end
  end

  logic [1:0]    pnl;
  logic [9:0]    ybase, ytop;
  logic [CW-1:0] col;
  logic          in_cell, blink_sup;
  logic          valid_d, valid_q;
  logic [7:0]    code_d, code_q;
  logic [9:0]    sx_d, sx_q, sy_d, sy_q;

  always_comb begin
    pnl   = 2'd0;
    ybase = 10'd0;
    if (y >= 10'(3 * PANEL_H)) begin
      pnl = 2'd3; ybase = 10'(3 * PANEL_H);
    end else if (y >= 10'(2 * PANEL_H)) begin
      pnl = 2'd2; ybase = 10'(2 * PANEL_H);
    end else if (y >= 10'(PANEL_H)) begin
      pnl = 2'd1; ybase = 10'(PANEL_H);
    end
    ytop    = ybase + 10'(TEXT_Y0);
    in_cell = display_area && (x >= X_LO) && (x < X_HI) &&
              (y >= ytop) && (y < ytop + 10'(CELL_H));
    col     = CW'((x - X_LO) >> $clog2(CELL_W));
    valid_d = in_cell & ~blink_sup;
    code_d  = in_cell ? front_q[pnl][col] : 8'h00;
    sx_d    = in_cell ? X_LO + 10'(col) * 10'(CELL_W) : 10'd0;
    sy_d    = in_cell ? ytop : 10'd0;
  end

`ifdef STATUS_PANEL_BLINK_EN
  logic [5:0] frame_q;
  logic       blink_q;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      frame_q <= 6'd0;
      blink_q <= 1'b0;
    end else if (commit) begin
      if (frame_q == 6'd59) begin
        frame_q <= 6'd0;
        blink_q <= ~blink_q;
      end else begin
        frame_q <= frame_q + 6'd1;
      end
    end
  end

  assign blink_sup = alarm[pnl] & blink_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^alarm;
  assign blink_sup    = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      valid_q <= 1'b0;
      code_q  <= 8'h00;
      sx_q    <= 10'd0;
      sy_q    <= 10'd0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  assign char_valid   = valid_q;
  assign char_code    = code_q;
  assign char_start_x = sx_q;
  assign char_start_y = sy_q;

endmodule
